mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the IF stage (instruction

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_timeout.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // Counter width able to hold the timeout limit itself; never narrower than 1 bit.
  function automatic int unsigned to_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

  localparam int unsigned TO_W = to_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mem_arb_timeout.sv
// Access watchdog: loadable up-counter of MemReq cycles; expired once the count hits LIMIT.
// LIMIT = 0 disables expiry entirely.
module mem_arb_timeout #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expired
);

  localparam logic [W-1:0] LIMIT_V = LIMIT[W-1:0];

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (cnt_q >= LIMIT_V);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported variable-latency memory between fetch (IF) and load/store (MEM).
// Optional build macro MEM_ARB_PERF_EN adds saturating performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  input  logic              FlushF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IDoneF,
  input  logic              DReqM,
  input  logic              DWriteM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DDoneM,
  output logic              StallMemF,
  output logic              StallMemM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       PerfIAccCnt,
  output logic [31:0]       PerfDAccCnt,
  output logic [31:0]       PerfStallCnt,
`endif
  output logic              BusErr
);

  localparam int unsigned CNT_W = to_width(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              kill_q, kill_d;
  logic              bus_err_q, bus_err_d;
  logic              in_acc, grant, expired;

  assign in_acc = (state_q == IACC) || (state_q == DACC);
  assign grant  = (state_q == IDLE) && (DReqM || IReqF);

  mem_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == RESP),
    .load     (grant),
    .load_val (CNT_W'(1)),
    .enable   (in_acc),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      kill_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      kill_q    <= kill_d;
      bus_err_q <= bus_err_d;
    end
  end

  // NOTE: every signal written here gets a hold-value default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    kill_d    = kill_q;
    bus_err_d = bus_err_q;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        // The load/store belongs to the older instruction, so it wins a tie.
        if (DReqM) begin
          state_d = DACC;
          owner_d = OWN_D;
          addr_d  = DAddrM;
          we_d    = DWriteM;
          wdata_d = DWdataM;
        end else if (IReqF) begin
          state_d = IACC;
          owner_d = OWN_I;
          addr_d  = IAddrF;
          we_d    = 1'b0;
        end
      end
      IACC, DACC: begin
        // A squashed fetch still completes on the bus; only its result is dropped.
        if (state_q == IACC && FlushF) begin
          kill_d = 1'b1;
        end
        if (MemAck) begin
          rdata_d = MemRdata;
          state_d = RESP;
        end else if (expired) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MemReq    = in_acc;
  assign MemWe     = in_acc && we_q;
  assign MemAddr   = addr_q;
  assign MemWdata  = wdata_q;
  assign IRdataF   = rdata_q;
  assign DRdataM   = rdata_q;
  // A flush arriving in the response cycle itself must also squash the result.
  assign IDoneF    = (state_q == RESP) && (owner_q == OWN_I) && !kill_q && !FlushF;
  assign DDoneM    = (state_q == RESP) && (owner_q == OWN_D);
  assign StallMemF = IReqF && !IDoneF;
  assign StallMemM = DReqM && !DDoneM;
  assign BusErr    = bus_err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_s_q <= '0;
    end else begin
      if (IDoneF && perf_i_q != '1) perf_i_q <= perf_i_q + 32'd1;
      if (DDoneM && perf_d_q != '1) perf_d_q <= perf_d_q + 32'd1;
      if ((StallMemF || StallMemM) && perf_s_q != '1) perf_s_q <= perf_s_q + 32'd1;
    end
  end

  assign PerfIAccCnt  = perf_i_q;
  assign PerfDAccCnt  = perf_d_q;
  assign PerfStallCnt = perf_s_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level timing model plus a
// memory responder, with a shadow memory for expected read data.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IReqF, FlushF, DReqM, DWriteM, MemAck;
  logic [31:0] IAddrF, DAddrM, DWdataM, MemRdata;
  logic [31:0] IRdataF, DRdataM, MemAddr, MemWdata;
  logic        IDoneF, DDoneM, StallMemF, StallMemM, MemReq, MemWe, BusErr;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_s;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .IReqF     (IReqF),
    .IAddrF    (IAddrF),
    .FlushF    (FlushF),
    .IRdataF   (IRdataF),
    .IDoneF    (IDoneF),
    .DReqM     (DReqM),
    .DWriteM   (DWriteM),
    .DAddrM    (DAddrM),
    .DWdataM   (DWdataM),
    .DRdataM   (DRdataM),
    .DDoneM    (DDoneM),
    .StallMemF (StallMemF),
    .StallMemM (StallMemM),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWdata  (MemWdata),
    .MemAck    (MemAck),
    .MemRdata  (MemRdata),
`ifdef MEM_ARB_PERF_EN
    .PerfIAccCnt  (perf_i),
    .PerfDAccCnt  (perf_d),
    .PerfStallCnt (perf_s),
`endif
    .BusErr    (BusErr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // bus_mem is what the bench-side memory actually holds; ref_mem is what it should hold.
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          bus_err_exp = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    int          lat;    // MemReq cycle carrying MemAck; 0 = never acknowledged
    int          start;  // grant cycle
    int          eff;    // MemReq cycles actually spent
    bit          to;     // ends by timeout
  } acc_t;

  function automatic acc_t mk_acc(input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit we, input int lat, input int start);
    acc_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.we    = we;
    r.lat   = lat;
    r.start = start;
    r.to    = (lat == 0);
    r.eff   = r.to ? TO : lat;
    return r;
  endfunction

  task automatic drive_idle();
    IReqF = 0; FlushF = 0; DReqM = 0; DWriteM = 0; MemAck = 0;
    IAddrF = '0; DAddrM = '0; DWdataM = '0; MemRdata = '0;
  endtask

  // One scenario starting with the arbiter in IDLE. fcyc < 0 means no flush pulse.
  task automatic run_scn(input bit has_i, input bit has_d, input bit d_we,
                         input logic [31:0] i_addr, input logic [31:0] i_addr2,
                         input logic [31:0] d_addr, input logic [31:0] d_wdata,
                         input int lat_i, input int lat_i2, input int lat_d, input int fcyc);
    acc_t a [3];
    int   n = 0;
    int   d_done = -1, i_done = -1, i_first_done, di = -1, ii = -1, last;
    bit   killed = 1'b0;
    bit   prev_req = 1'b0;
    int   ri = -1, rc = 0;

    if (has_d) begin
      a[n]   = mk_acc(d_addr, d_wdata, d_we, lat_d, 0);
      d_done = a[n].eff + 1;
      di     = n;
      n++;
    end
    if (has_i) begin
      a[n]         = mk_acc(i_addr, '0, 1'b0, lat_i, has_d ? d_done + 1 : 0);
      i_first_done = a[n].start + a[n].eff + 1;
      killed       = (fcyc > a[n].start) && (fcyc <= i_first_done);
      ii           = n;
      n++;
      if (killed) begin
        a[n] = mk_acc(i_addr2, '0, 1'b0, lat_i2, i_first_done + 1);
        ii   = n;
        n++;
      end
      i_done = a[ii].start + a[ii].eff + 1;
    end
    last = ((d_done > i_done) ? d_done : i_done) + 1;

    for (int c = 0; c <= last; c++) begin
      bit exp_req, exp_id, exp_dd;
      int k_act;
      @(negedge clk);
      // Memory responder: acknowledges on the configured MemReq cycle of each access.
      MemAck   = 1'b0;
      MemRdata = $urandom;
      if (MemReq) begin
        if (!prev_req) begin
          ri++;
          rc = 1;
        end else begin
          rc++;
        end
        if (ri < n && a[ri].lat == rc) begin
          MemAck = 1'b1;
          if (MemWe) bus_mem[MemAddr] = MemWdata;
          else       MemRdata = bus_rd(MemAddr);
        end
      end
      prev_req = MemReq;

      DReqM   = has_d && (c <= d_done);
      DWriteM = d_we;
      DAddrM  = d_addr;
      DWdataM = d_wdata;
      IReqF   = has_i && (c <= i_done);
      IAddrF  = (killed && c >= fcyc) ? i_addr2 : i_addr;
      FlushF  = (c == fcyc);
      #1;

      exp_req = 1'b0;
      k_act   = -1;
      for (int k = 0; k < n; k++) begin
        if (c > a[k].start && c <= a[k].start + a[k].eff) begin
          exp_req = 1'b1;
          k_act   = k;
        end
        if (a[k].to && c == a[k].start + a[k].eff + 1) bus_err_exp = 1'b1;
      end
      exp_dd = (c == d_done);
      exp_id = (c == i_done);

      check("MemReq", MemReq, exp_req);
      if (k_act >= 0) begin
        check("MemAddr", MemAddr, a[k_act].addr);
        check("MemWe", MemWe, a[k_act].we);
        if (a[k_act].we) check("MemWdata", MemWdata, a[k_act].wdata);
      end
      check("IDoneF", IDoneF, exp_id);
      check("DDoneM", DDoneM, exp_dd);
      check("StallMemF", StallMemF, IReqF && !exp_id);
      check("StallMemM", StallMemM, DReqM && !exp_dd);
      check("BusErr", BusErr, bus_err_exp);

      if (exp_dd) begin
        if (!d_we) check("DRdataM", DRdataM, a[di].to ? 32'h0 : ref_rd(d_addr));
        else if (!a[di].to) ref_mem[d_addr] = d_wdata;
      end
      if (exp_id) check("IRdataF", IRdataF, a[ii].to ? 32'h0 : ref_rd(a[ii].addr));
    end
    drive_idle();
  endtask

  function automatic int pick_lat();
    int r = int'($urandom_range(0, 9));
    return (r == 0) ? 0 : 1 + (r % 4);
  endfunction

  initial begin
    drive_idle();
    reset_n = 1'b0;
    bus_mem[32'h40] = 32'h2002000A;
    ref_mem[32'h40] = 32'h2002000A;
    #1;
    check("rst_MemReq", MemReq, 0);
    check("rst_IDoneF", IDoneF, 0);
    check("rst_DDoneM", DDoneM, 0);
    check("rst_BusErr", BusErr, 0);
    check("rst_MemAddr", MemAddr, 0);
    check("rst_IRdataF", IRdataF, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single fetch, ack on third MemReq cycle: IDoneF at cycle 4.
    run_scn(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 3, 0, 0, -1);
    // Simultaneous load and fetch: load first.
    run_scn(1, 1, 0, 32'h44, 32'h0, 32'h100, 32'h0, 2, 0, 2, -1);
    // Store then read back through the bus.
    run_scn(0, 1, 1, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF, 0, 0, 3, -1);
    run_scn(0, 1, 0, 32'h0, 32'h0, 32'h200, 32'h0, 0, 0, 1, -1);
    // Flush mid-fetch, refetch from 0x80; then flush in the response cycle.
    run_scn(1, 0, 0, 32'h60, 32'h80, 32'h0, 32'h0, 3, 2, 0, 2);
    run_scn(1, 0, 0, 32'h64, 32'h84, 32'h0, 32'h0, 2, 1, 0, 3);
    // Ack on the limit cycle beats the timeout; then genuine timeouts.
    run_scn(0, 1, 0, 32'h0, 32'h0, 32'h104, 32'h0, 0, 0, TO, -1);
    run_scn(1, 1, 0, 32'h48, 32'h0, 32'h108, 32'h0, 0, 0, 0, -1);

    // Reset while a load is on the bus.
    @(negedge clk);
    DReqM = 1; DAddrM = 32'h300; DWriteM = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_MemReq", MemReq, 1);
    check("pre_rst_BusErr", BusErr, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_MemReq", MemReq, 0);
    check("mid_rst_MemAddr", MemAddr, 0);
    check("mid_rst_DDoneM", DDoneM, 0);
    check("mid_rst_BusErr", BusErr, 0);
    drive_idle();
    bus_err_exp = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_scn(0, 1, 0, 32'h0, 32'h0, 32'h300, 32'h0, 0, 0, 0, -1);

    for (int t = 0; t < 80; t++) begin
      int          kind = int'($urandom_range(0, 3));
      int          li = pick_lat(), li2 = pick_lat(), ld = pick_lat();
      int          ei = (li == 0) ? TO : li, ed = (ld == 0) ? TO : ld;
      int          fc = -1;
      logic [31:0] ia  = 32'h40 + 32'($urandom_range(0, 7)) * 4;
      logic [31:0] ia2 = 32'h80 + 32'($urandom_range(0, 7)) * 4;
      logic [31:0] da  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      logic [31:0] wd  = $urandom;
      bit          we  = 1'($urandom_range(0, 1));
      case (kind)
        0: run_scn(1, 0, 0, ia, ia2, da, wd, li, li2, ld, -1);
        1: run_scn(0, 1, we, ia, ia2, da, wd, li, li2, ld, -1);
        2: begin
          if ($urandom_range(0, 1) == 1) fc = int'($urandom_range(1, ed));
          run_scn(1, 1, we, ia, ia2, da, wd, li, li2, ld, fc);
        end
        default: begin
          fc = int'($urandom_range(0, ei + 1));
          run_scn(1, 0, 0, ia, ia2, da, wd, li, li2, ld, fc);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
